// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - config word handshake, ccff chain and status bundle
// CCFF_READBACK_EN adds rb_data/rb_valid and routes ccff_tail into the loader.
interface ccff_chain_loader_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_en;
  logic              ccff_tail;
  logic              IO_ISOL_N;
  logic              busy;
  logic              done;
`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;

  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, ccff_en, IO_ISOL_N, busy, done, rb_data, rb_valid
  );
  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_en, IO_ISOL_N, busy, done, rb_data, rb_valid
  );
`else
  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, ccff_head, ccff_en, IO_ISOL_N, busy, done
  );
  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_en, IO_ISOL_N, busy, done
  );
`endif
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes config words LSB-first onto the ccff chain
// Optional chain readback of ccff_tail is enabled with CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  ccff_chain_loader_if.slave   bus
);
  localparam int REM_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bits_q, bits_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              ready_q, ready_d;
  logic              en_q, en_d;
  logic              head_q, head_d;
  logic              iso_q, iso_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic [REM_W-1:0]  k;

  assign accept = (state_q == LOAD) && bus.cfg_valid && ready_q;
  // Bits left to send this word: a full word, or whatever the chain still needs.
  assign k = ((CHAIN_LEN - int'(bits_q)) < DATA_W) ? REM_W'(CHAIN_LEN - int'(bits_q))
                                                   : REM_W'(DATA_W);

  always_ff @(posedge prog_clk) begin
    if (pReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (accept) state_d = SHIFT;
      SHIFT:   if (rem_q == REM_W'(1))
                 state_d = ((int'(bits_q) + 1) == CHAIN_LEN) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    en_d    = 1'b0;
    head_d  = 1'b0;
    done_d  = 1'b0;
    iso_d   = iso_q;
    busy_d  = (state_d != IDLE);
    bits_d  = bits_q;
    rem_d   = rem_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (bus.start) begin
        ready_d = 1'b1;
        iso_d   = 1'b0;
        bits_d  = '0;
      end
      LOAD: if (accept) begin
        en_d   = 1'b1;
        head_d = bus.cfg_data[0];
        word_d = bus.cfg_data >> 1;
        rem_d  = k;
      end else begin
        ready_d = 1'b1;
      end
      SHIFT: begin
        bits_d = bits_q + CNT_W'(1);
        rem_d  = rem_q - REM_W'(1);
        if (state_d == SHIFT) begin
          en_d   = 1'b1;
          head_d = word_q[0];
          word_d = word_q >> 1;
        end else if (state_d == DONE) begin
          done_d = 1'b1;
          iso_d  = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      bits_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      head_q  <= 1'b0;
      iso_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      head_q  <= head_d;
      iso_q   <= iso_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.cfg_ready = ready_q;
  assign bus.ccff_en   = en_q;
  assign bus.ccff_head = head_q;
  assign bus.IO_ISOL_N = iso_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] rb_acc_q, rb_data_q, rb_word;
  logic [REM_W-1:0]  rb_idx_q;
  logic              rb_valid_q;

  // rem_q==1 on an enabled cycle marks the last bit of a word, full or partial.
  assign rb_word = rb_acc_q | (DATA_W'(bus.ccff_tail) << rb_idx_q);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rb_acc_q   <= '0;
      rb_data_q  <= '0;
      rb_idx_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (en_q) begin
        if (rem_q == REM_W'(1)) begin
          rb_data_q  <= rb_word;
          rb_valid_q <= 1'b1;
          rb_acc_q   <= '0;
          rb_idx_q   <= '0;
        end else begin
          rb_acc_q <= rb_word;
          rb_idx_q <= rb_idx_q + REM_W'(1);
        end
      end
    end
  end

  assign bus.rb_data  = rb_data_q;
  assign bus.rb_valid = rb_valid_q;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - randomized self-checking bench for ccff_chain_loader
// Two instances (16- and 10-bit chains); CCFF_READBACK_EN adds a modelled chain on unit 0.
module tb_ccff_chain_loader;
  localparam int DW = 8;
  localparam int NU = 2;
  localparam int HN = 4096;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.DATA_W(DW)) if0 ();
  ccff_chain_loader_if #(.DATA_W(DW)) if1 ();

  ccff_chain_loader #(.CHAIN_LEN(16), .DATA_W(DW)) dut0 (.prog_clk(prog_clk), .pReset(pReset), .bus(if0));
  ccff_chain_loader #(.CHAIN_LEN(10), .DATA_W(DW)) dut1 (.prog_clk(prog_clk), .pReset(pReset), .bus(if1));

  logic          start_r [NU];
  logic          valid_r [NU];
  logic [DW-1:0] data_r  [NU];
  logic rdy_o [NU], en_o [NU], head_o [NU], iso_o [NU], busy_o [NU], done_o [NU];

  assign if0.start = start_r[0];  assign if0.cfg_valid = valid_r[0];  assign if0.cfg_data = data_r[0];
  assign if1.start = start_r[1];  assign if1.cfg_valid = valid_r[1];  assign if1.cfg_data = data_r[1];
  assign rdy_o[0] = if0.cfg_ready; assign en_o[0] = if0.ccff_en; assign head_o[0] = if0.ccff_head;
  assign iso_o[0] = if0.IO_ISOL_N; assign busy_o[0] = if0.busy;  assign done_o[0] = if0.done;
  assign rdy_o[1] = if1.cfg_ready; assign en_o[1] = if1.ccff_en; assign head_o[1] = if1.ccff_head;
  assign iso_o[1] = if1.IO_ISOL_N; assign busy_o[1] = if1.busy;  assign done_o[1] = if1.done;
  assign if1.ccff_tail = 1'b0;

`ifdef CCFF_READBACK_EN
  logic [15:0]   chain = '0;
  logic          preload_req = 1'b0;
  logic [15:0]   preload_val = '0;
  logic [DW-1:0] rb_hist [64];
  int            rb_cnt = 0;
  always @(posedge prog_clk) begin
    if (preload_req)     chain <= preload_val;
    else if (if0.ccff_en) chain <= {if0.ccff_head, chain[15:1]};
  end
  assign if0.ccff_tail = chain[0];
`else
  assign if0.ccff_tail = 1'b0;
`endif

  int   cyc = 0;
  int   en_cnt [NU] = '{0, 0};
  int   acc_cnt [NU] = '{0, 0};
  int   done_cnt [NU] = '{0, 0};
  int   head_bad [NU] = '{0, 0};
  int   iso_bad [NU] = '{0, 0};
  int   idle_rdy [NU] = '{0, 0};
  logic head_hist [NU][HN];

  always @(posedge prog_clk) cyc <= cyc + 1;

  always @(negedge prog_clk) begin
    for (int u = 0; u < NU; u++) begin
      if (en_o[u] === 1'b1) begin
        head_hist[u][en_cnt[u] % HN] <= head_o[u];
        en_cnt[u] <= en_cnt[u] + 1;
      end
      if (valid_r[u] && rdy_o[u] === 1'b1) acc_cnt[u] <= acc_cnt[u] + 1;
      if (done_o[u] === 1'b1) done_cnt[u] <= done_cnt[u] + 1;
      if (en_o[u] === 1'b0 && head_o[u] === 1'b1) head_bad[u] <= head_bad[u] + 1;
      if (busy_o[u] === 1'b1 && done_o[u] === 1'b0 && iso_o[u] === 1'b1) iso_bad[u] <= iso_bad[u] + 1;
      if (busy_o[u] === 1'b0 && rdy_o[u] === 1'b1) idle_rdy[u] <= idle_rdy[u] + 1;
    end
`ifdef CCFF_READBACK_EN
    if (if0.rb_valid === 1'b1) begin
      rb_hist[rb_cnt % 64] <= if0.rb_data;
      rb_cnt <= rb_cnt + 1;
    end
`endif
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int chain_len(input int u);
    return (u == 0) ? 16 : 10;
  endfunction

  function automatic logic [5:0] status(input int u);
    return {rdy_o[u], en_o[u], head_o[u], busy_o[u], done_o[u], iso_o[u]};
  endfunction

  logic [DW-1:0] wbuf [8];
  int            gbuf [8];

  // Reference: the chain receives the words' bits in order, LSB first, cut at the chain length.
  task automatic run_load(input int u, input int nw, input bit poke);
    int cl, acc0, en0, dn0, hb0, ib0, ir0, wi, stall, lat, extra, c0;
    bit seen, poked;
    logic [63:0] exp_s, obs_s;
`ifdef CCFF_READBACK_EN
    int rb0;
    logic [15:0] prev;
    rb0 = rb_cnt;
    prev = chain;
`endif
    cl = chain_len(u);
    exp_s = '0;
    obs_s = '0;
    extra = 0;
    for (int i = 0; i < cl; i++) exp_s[i] = wbuf[i / DW][i % DW];
    for (int j = 1; j < nw; j++) extra += gbuf[j];
    acc0 = acc_cnt[u]; en0 = en_cnt[u]; dn0 = done_cnt[u];
    hb0 = head_bad[u]; ib0 = iso_bad[u]; ir0 = idle_rdy[u];
    start_r[u] = 1'b1; valid_r[u] = 1'b1; data_r[u] = wbuf[0];
    c0 = cyc; wi = 0; stall = 0; seen = 1'b0; poked = 1'b0; lat = -1;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(posedge prog_clk); #1;
      start_r[u] = 1'b0;
      if (poke && !poked && en_o[u]) begin start_r[u] = 1'b1; poked = 1'b1; end
      if (done_o[u]) begin seen = 1'b1; lat = cyc - c0; end
      if (acc_cnt[u] - acc0 > wi) begin
        wi++;
        stall = 0;
        if (wi < nw) begin
          data_r[u] = wbuf[wi];
          valid_r[u] = (gbuf[wi] == 0);
        end else begin
          data_r[u] = DW'($urandom);
          valid_r[u] = 1'b0;
        end
      end else if (wi < nw && !valid_r[u] && rdy_o[u]) begin
        if (stall == gbuf[wi]) valid_r[u] = 1'b1;
        else stall++;
      end
    end
    if (!seen) expect_eq("done_timeout", 0, 1);
    valid_r[u] = 1'b0;
    repeat (2) begin @(posedge prog_clk); #1; end
    for (int i = 0; i < cl; i++) obs_s[i] = head_hist[u][(en0 + i) % HN];
    expect_eq("latency", lat, 1 + nw + cl + extra);
    expect_eq("stream", obs_s, exp_s);
    expect_eq("en_cycles", en_cnt[u] - en0, cl);
    expect_eq("words", acc_cnt[u] - acc0, nw);
    expect_eq("done_pulses", done_cnt[u] - dn0, 1);
    expect_eq("iso_after", iso_o[u], 1);
    expect_eq("busy_after", busy_o[u], 0);
    expect_eq("iso_during", iso_bad[u] - ib0, 0);
    expect_eq("head_when_idle", head_bad[u] - hb0, 0);
    expect_eq("ready_in_idle", idle_rdy[u] - ir0, 0);
`ifdef CCFF_READBACK_EN
    if (u == 0) begin
      expect_eq("rb_count", rb_cnt - rb0, 2);
      expect_eq("rb_word0", rb_hist[rb0 % 64], prev[7:0]);
      expect_eq("rb_word1", rb_hist[(rb0 + 1) % 64], prev[15:8]);
      expect_eq("chain_new", chain, exp_s[15:0]);
    end
`endif
  endtask

  task automatic idle_valid(input int u);
    int acc0, ir0;
    acc0 = acc_cnt[u];
    ir0 = idle_rdy[u];
    valid_r[u] = 1'b1;
    data_r[u] = DW'($urandom);
    repeat (6) begin @(posedge prog_clk); #1; end
    valid_r[u] = 1'b0;
    expect_eq("idle_accept", acc_cnt[u] - acc0, 0);
    expect_eq("idle_ready", idle_rdy[u] - ir0, 0);
    expect_eq("idle_busy", busy_o[u], 0);
  endtask

  task automatic reset_mid(input int u);
    int en0;
    bit hit;
    en0 = en_cnt[u];
    hit = 1'b0;
    start_r[u] = 1'b1; valid_r[u] = 1'b1; data_r[u] = DW'($urandom);
    for (int t = 0; t < 100 && !hit; t++) begin
      @(posedge prog_clk); #1;
      start_r[u] = 1'b0;
      hit = (en_cnt[u] - en0 == 4) && en_o[u];
    end
    if (!hit) expect_eq("fifth_bit_timeout", 0, 1);
    pReset = 1'b1;
    valid_r[u] = 1'b0;
    @(posedge prog_clk); #1;
    pReset = 1'b0;
    expect_eq("midreset_status", status(u), 6'b0);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      start_r[u] = 1'b0; valid_r[u] = 1'b0; data_r[u] = '0;
    end
    for (int j = 0; j < 8; j++) begin wbuf[j] = '0; gbuf[j] = 0; end
    repeat (3) @(posedge prog_clk);
    #1;
    expect_eq("reset_u0", status(0), 6'b0);
    expect_eq("reset_u1", status(1), 6'b0);
    pReset = 1'b0;
`ifdef CCFF_READBACK_EN
    preload_val = 16'h3C5A;
    preload_req = 1'b1;
    @(posedge prog_clk); #1;
    preload_req = 1'b0;
`endif
    @(posedge prog_clk); #1;
    expect_eq("post_reset_u0", status(0), 6'b0);

    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    run_load(0, 2, 1'b0);
    wbuf[0] = 8'hFF; wbuf[1] = 8'hFE;
    run_load(1, 2, 1'b0);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; gbuf[1] = 5;
    run_load(0, 2, 1'b0);
    gbuf[1] = 0;
    run_load(0, 2, 1'b1);
    run_load(1, 2, 1'b1);
    idle_valid(0);
    idle_valid(1);
    reset_mid(0);
    run_load(0, 2, 1'b0);

    for (int it = 0; it < 10; it++) begin
      for (int j = 0; j < 2; j++) begin
        wbuf[j] = DW'($urandom);
        gbuf[j] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      end
      run_load(it % 2, 2, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
